// File: rtl/store_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module   : store_buffer_if
//  Purpose  : Bundles the store-buffer signals: MEM-stage store handshake,
//             load snoop, fence handshake, data-memory write port and status.
//  Modports : master - MEM stage / environment side (drives st_*, ld_*, fence_req)
//             slave  - store buffer side (drives st_ready, ld_conflict, dm_*, ...)
//  Revision : 1.0  initial release
// ============================================================================
interface store_buffer_if #(
    parameter int AW    = 9,
    parameter int DEPTH = 4
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    // Store retire from MEM
    logic          st_valid;
    logic [2:0]    st_type;
    logic [AW-1:0] st_addr;
    logic [31:0]   st_data;
    logic          st_ready;
    logic          st_misalign;
    // Load snoop
    logic          ld_active;
    logic [AW-1:0] ld_addr;
    logic          ld_conflict;
    // Fence
    logic          fence_req;
    logic          fence_busy;
    logic          fence_done;
    // Data-memory write port
    logic          dm_we;
    logic [2:0]    dm_type;
    logic [AW-1:0] dm_addr;
    logic [31:0]   dm_wdata;
    // Status
    logic          empty;
    logic [CW-1:0] count;

    modport master (
        output st_valid, st_type, st_addr, st_data, ld_active, ld_addr, fence_req,
        input  st_ready, st_misalign, ld_conflict, fence_busy, fence_done,
               dm_we, dm_type, dm_addr, dm_wdata, empty, count
    );

    modport slave (
        input  st_valid, st_type, st_addr, st_data, ld_active, ld_addr, fence_req,
        output st_ready, st_misalign, ld_conflict, fence_busy, fence_done,
               dm_we, dm_type, dm_addr, dm_wdata, empty, count
    );
endinterface
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : store_buffer
//  Purpose  : Posted-write FIFO between MEM and data memory. Stores enqueue in
//             one cycle, drain whenever the memory port is free of a load (or
//             a load conflicts with a pending store, or a fence is flushing).
//  Ports    : clk  - rising-edge clock
//             rst  - asynchronous active-high reset
//             bus  - store_buffer_if.slave (store, load snoop, fence, dm port,
//                    empty/count status)
//  Revision : 1.0  initial release
// ============================================================================
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 9
) (
    input  wire logic      clk,
    input  wire logic      rst,
    store_buffer_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [2:0] C_DM_BYTE = 3'b000;
    localparam logic [2:0] C_DM_HALF = 3'b001;
    localparam logic [2:0] C_DM_WORD = 3'b010;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [2:0]    r_type [DEPTH];
    logic [AW-1:0] r_addr [DEPTH];
    logic [31:0]   r_data [DEPTH];

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          r_misalign;

    logic          w_aligned;
    logic          w_ready;
    logic          w_enq;
    logic          w_drain;
    logic          w_conflict;
    logic [DEPTH-1:0] w_hit;
    logic          w_unused;

    // Byte-lane bits of the load address do not matter at word granularity.
    assign w_unused = ^bus.ld_addr[1:0];

    always_comb begin
        w_aligned = 1'b1;
        case (bus.st_type)
            C_DM_WORD: w_aligned = (bus.st_addr[1:0] == 2'b00);
            C_DM_HALF: w_aligned = (bus.st_addr[0] == 1'b0);
            C_DM_BYTE: w_aligned = 1'b1;
            default:   w_aligned = 1'b1;
        endcase
    end

    // Ready deliberately ignores a same-cycle drain so it never depends on
    // the load snoop path beyond count/state.
    assign w_ready = (r_count < CW'(DEPTH)) && (r_state == RUN);
    assign w_enq   = bus.st_valid && w_ready && w_aligned;

    // An entry is live when its distance from head is below count.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [PW-1:0] w_off;
        assign w_off     = PW'(gi) - r_head;
        assign w_hit[gi] = ({1'b0, w_off} < r_count) &&
                           (r_addr[gi][AW-1:2] == bus.ld_addr[AW-1:2]);
    end

    assign w_conflict = bus.ld_active && (|w_hit);
    // Draining on a conflict lets the stalled load make progress.
    assign w_drain    = (r_count != '0) &&
                        (!bus.ld_active || w_conflict || (r_state == FLUSH));

    // Entry storage needs no reset: liveness is tracked by head/count.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_type[r_tail] <= bus.st_type;
            r_addr[r_tail] <= bus.st_addr;
            r_data[r_tail] <= bus.st_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_misalign <= 1'b0;
            r_state    <= RUN;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_drain) begin
                r_head <= r_head + PW'(1);
            end
            case ({w_enq, w_drain})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            r_misalign <= bus.st_valid && w_ready && !w_aligned;
            r_state    <= w_state_nxt;
        end
    end

    // FLUSH drains every cycle, so count<=1 means empty after this edge.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (bus.fence_req) w_state_nxt = FLUSH;
            FLUSH:   if (r_count <= CW'(1)) w_state_nxt = DONE;
            DONE:    w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    assign bus.st_ready    = w_ready;
    assign bus.st_misalign = r_misalign;
    assign bus.ld_conflict = w_conflict;
    assign bus.fence_busy  = (r_state == FLUSH);
    assign bus.fence_done  = (r_state == DONE);
    assign bus.dm_we       = w_drain;
    assign bus.dm_type     = r_type[r_head];
    assign bus.dm_addr     = r_addr[r_head];
    assign bus.dm_wdata    = r_data[r_head];
    assign bus.empty       = (r_count == '0);
    assign bus.count       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_store_buffer
//  Purpose  : Self-checking bench for store_buffer. A queue-based reference
//             model predicts every output each cycle; directed scenarios are
//             followed by a randomized phase.
//  Revision : 1.0  initial release
// ============================================================================
module tb_store_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 9;

    localparam logic [2:0] T_BYTE = 3'b000;
    localparam logic [2:0] T_HALF = 3'b001;
    localparam logic [2:0] T_WORD = 3'b010;

    typedef struct packed {
        logic [2:0]    t;
        logic [AW-1:0] a;
        logic [31:0]   d;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    store_buffer_if #(.AW(AW), .DEPTH(DEPTH)) sbif ();

    store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sbif)
    );

    // Reference model state
    ent_t q[$];          // pending stores, oldest first
    int   mode;          // 0 = accepting, 1 = draining for fence, 2 = fence done
    bit   mis_prev;
    ent_t dut_log[$];    // writes the DUT actually issued

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, check at negedge,
    // advance the model at the next rising edge.
    task automatic step(input bit v, input logic [2:0] t, input logic [AW-1:0] a,
                        input logic [31:0] d, input bit ld, input logic [AW-1:0] la,
                        input bit f);
        bit e_ready, e_conf, e_drain, al;
        sbif.st_valid  = v;
        sbif.st_type   = t;
        sbif.st_addr   = a;
        sbif.st_data   = d;
        sbif.ld_active = ld;
        sbif.ld_addr   = la;
        sbif.fence_req = f;

        e_ready = (q.size() < DEPTH) && (mode == 0);
        e_conf  = 1'b0;
        if (ld) foreach (q[i]) if (q[i].a[AW-1:2] == la[AW-1:2]) e_conf = 1'b1;
        e_drain = (q.size() > 0) && (!ld || e_conf || mode == 1);
        if (t == T_WORD)      al = (a[1:0] == 2'b00);
        else if (t == T_HALF) al = (a[0] == 1'b0);
        else                  al = 1'b1;

        @(negedge clk);
        check("st_ready",    sbif.st_ready,    e_ready);
        check("ld_conflict", sbif.ld_conflict, e_conf);
        check("dm_we",       sbif.dm_we,       e_drain);
        check("count",       sbif.count,       q.size());
        check("empty",       sbif.empty,       q.size() == 0);
        check("fence_busy",  sbif.fence_busy,  mode == 1);
        check("fence_done",  sbif.fence_done,  mode == 2);
        check("st_misalign", sbif.st_misalign, mis_prev);
        if (e_drain) begin
            check("dm_type",  sbif.dm_type,  q[0].t);
            check("dm_addr",  sbif.dm_addr,  q[0].a);
            check("dm_wdata", sbif.dm_wdata, q[0].d);
        end
        if (sbif.dm_we) dut_log.push_back('{sbif.dm_type, sbif.dm_addr, sbif.dm_wdata});

        @(posedge clk);
        if (e_drain) void'(q.pop_front());
        if (v && e_ready && al) q.push_back('{t, a, d});
        mis_prev = v && e_ready && !al;
        case (mode)
            0:       if (f) mode = 1;
            1:       if (q.size() == 0) mode = 2;
            default: mode = 0;
        endcase
        #1;
    endtask

    task automatic idle(input bit ld, input logic [AW-1:0] la);
        step(1'b0, T_BYTE, '0, '0, ld, la, 1'b0);
    endtask

    task automatic model_reset();
        q.delete();
        mode     = 0;
        mis_prev = 1'b0;
    endtask

    localparam logic [AW-1:0] FAR = 9'h1F0;

    initial begin
        int n0;
        sbif.st_valid  = 1'b0;
        sbif.st_type   = T_BYTE;
        sbif.st_addr   = '0;
        sbif.st_data   = '0;
        sbif.ld_active = 1'b0;
        sbif.ld_addr   = '0;
        sbif.fence_req = 1'b0;
        model_reset();

        // Reset state
        #2 rst = 1'b1;
        #2;
        check("rst_count",       sbif.count,       0);
        check("rst_st_ready",    sbif.st_ready,    1);
        check("rst_dm_we",       sbif.dm_we,       0);
        check("rst_ld_conflict", sbif.ld_conflict, 0);
        check("rst_st_misalign", sbif.st_misalign, 0);
        check("rst_fence_busy",  sbif.fence_busy,  0);
        check("rst_fence_done",  sbif.fence_done,  0);
        check("rst_empty",       sbif.empty,       1);
        @(negedge clk) rst = 1'b0;
        @(posedge clk) #1;

        // Single drain
        n0 = dut_log.size();
        step(1'b1, T_WORD, 9'h010, 32'hDEADBEEF, 1'b0, '0, 1'b0);
        idle(1'b0, '0);
        idle(1'b0, '0);
        check("single_nwr", dut_log.size() - n0, 1);
        if (dut_log.size() > n0) begin
            check("single_addr", dut_log[n0].a, 9'h010);
            check("single_type", dut_log[n0].t, T_WORD);
            check("single_data", dut_log[n0].d, 32'hDEADBEEF);
        end

        // Fill and block, then release in FIFO order
        n0 = dut_log.size();
        for (int i = 0; i < 4; i++)
            step(1'b1, T_WORD, AW'(9'h040 + 4 * i), 32'h1000 + i, 1'b1, FAR, 1'b0);
        idle(1'b1, FAR);
        check("fill_count", sbif.count, 4);
        for (int i = 0; i < 5; i++) idle(1'b0, '0);
        check("fill_nwr", dut_log.size() - n0, 4);
        for (int i = 0; i < 4; i++)
            if (dut_log.size() > n0 + i)
                check("fill_order", dut_log[n0 + i].a, AW'(9'h040 + 4 * i));

        // Conflict: byte store at 0x023, load at 0x020
        step(1'b1, T_BYTE, 9'h023, 32'h5A, 1'b1, FAR, 1'b0);
        step(1'b0, T_BYTE, '0, '0, 1'b1, 9'h020, 1'b0);
        idle(1'b1, 9'h020);

        // Misalignment: halfword at odd address dropped, byte accepted
        step(1'b1, T_HALF, 9'h011, 32'h1234, 1'b1, FAR, 1'b0);
        idle(1'b1, FAR);
        idle(1'b1, FAR);
        step(1'b1, T_BYTE, 9'h013, 32'h77, 1'b1, FAR, 1'b0);
        idle(1'b1, FAR);
        check("misalign_byte_count", sbif.count, 1);
        idle(1'b0, '0);

        // Fence with 3 pending while loads keep the port busy
        for (int i = 0; i < 3; i++)
            step(1'b1, T_WORD, AW'(9'h080 + 4 * i), 32'hF00 + i, 1'b1, FAR, 1'b0);
        step(1'b0, T_BYTE, '0, '0, 1'b1, FAR, 1'b1);
        for (int i = 0; i < 6; i++) idle(1'b1, FAR);
        // Fence on an empty buffer
        step(1'b0, T_BYTE, '0, '0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 4; i++) idle(1'b0, '0);

        // Reset mid-drain
        for (int i = 0; i < 3; i++)
            step(1'b1, T_WORD, AW'(9'h0C0 + 4 * i), 32'hABC0 + i, 1'b1, FAR, 1'b0);
        sbif.st_valid  = 1'b0;
        sbif.ld_active = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_count", sbif.count, 0);
        check("midrst_dm_we", sbif.dm_we, 0);
        check("midrst_empty", sbif.empty, 1);
        model_reset();
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk) #1;
        n0 = dut_log.size();
        for (int i = 0; i < 3; i++) idle(1'b0, '0);
        check("midrst_nostale", dut_log.size() - n0, 0);

        // Randomized traffic in a small address window to provoke conflicts
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 2)),
                 AW'($urandom_range(0, 63)),
                 $urandom,
                 $urandom_range(0, 2) != 0,
                 AW'($urandom_range(0, 63)),
                 $urandom_range(0, 40) == 0);
        end
        for (int i = 0; i < 8; i++) idle(1'b0, '0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
